// File: rtl/verificador_tabla_pkg.sv
// Shared types and constants for the truth-table response checker.
// The MISR constants apply only when VERIFICADOR_FIRMA_EN is defined.
package verificador_tabla_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // x^16 + x^12 + x^5 + 1
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'h0000;

endpackage

// File: rtl/verificador_tabla_firma_misr.sv
// 16-bit serial-input MISR with synchronous clear and shift enable.
// Instantiated by verificador_tabla only when VERIFICADOR_FIRMA_EN is defined.
module firma_misr
    import verificador_tabla_pkg::*;
#(
    parameter logic [15:0] POLY = MISR_POLY,
    parameter logic [15:0] SEED = MISR_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic fb;

    assign fb = sig[15] ^ din;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig <= SEED;
        end else if (clr) begin
            sig <= SEED;
        end else if (en) begin
            sig <= {sig[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/verificador_tabla.sv
// Sweeps all 2^K input vectors into a combinational DUT and counts f_ref/f_red mismatches.
// Define VERIFICADOR_FIRMA_EN to add the 16-bit f_ref signature output `firma`.
module verificador_tabla
    import verificador_tabla_pkg::*;
#(
    parameter int K      = 5,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [K-1:0] vec,
    input  logic         f_ref,
    input  logic         f_red,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [K:0]   err_count,
`ifdef VERIFICADOR_FIRMA_EN
    output logic [15:0]  firma,
`endif
    output logic [K-1:0] first_err
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t        state, state_n;
    logic [SW-1:0] settle_cnt;
    logic          accept;
    logic          sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        sample  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                busy = 1'b1;
                if (settle_cnt == SW'(SETTLE - 1)) begin
                    sample = 1'b1;
                    if (vec == '1) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_n = ST_SWEEP;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // vec wraps to 0 naturally when the last vector is sampled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec        <= '0;
            err_count  <= '0;
            first_err  <= '0;
            settle_cnt <= '0;
        end else if (accept) begin
            vec        <= '0;
            err_count  <= '0;
            first_err  <= '0;
            settle_cnt <= '0;
        end else if (sample) begin
            if (f_ref != f_red) begin
                err_count <= err_count + 1'b1;
                if (err_count == '0) begin
                    first_err <= vec;
                end
            end
            vec        <= vec + 1'b1;
            settle_cnt <= '0;
        end else if (state == ST_SWEEP) begin
            settle_cnt <= settle_cnt + 1'b1;
        end
    end

    assign pass = done && (err_count == '0);

`ifdef VERIFICADOR_FIRMA_EN
    firma_misr #(
        .POLY(MISR_POLY),
        .SEED(MISR_SEED)
    ) u_firma (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .en   (sample),
        .din  (f_ref),
        .sig  (firma)
    );
`endif

endmodule

// File: tb/tb_verificador_tabla.sv
// Scoreboard bench for verificador_tabla: stimulus queues expected sweep results, a monitor checks them at done.
module tb_verificador_tabla;

    localparam int K      = 5;
    localparam int SETTLE = 2;
    localparam int LAT    = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [K-1:0] vec;
    logic         f_ref;
    logic         f_red;
    logic         busy;
    logic         done;
    logic         pass;
    logic [K:0]   err_count;
    logic [K-1:0] first_err;
`ifdef VERIFICADOR_FIRMA_EN
    logic [15:0]  firma;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        int unsigned errs;
        int unsigned first;
        bit          ok;
    } exp_t;

    exp_t sb[$];
    int   red_mode = 0;
    int   ref_mode = 0;

    always #5 clk = ~clk;

    verificador_tabla #(.K(K), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .vec      (vec),
        .f_ref    (f_ref),
        .f_red    (f_red),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
`ifdef VERIFICADOR_FIRMA_EN
        .firma    (firma),
`endif
        .first_err(first_err)
    );

    function automatic logic fref_fn(logic [K-1:0] v, int mode);
        logic b;
        b = ((v[4] & v[3]) | (~v[2] & v[0])) ^ v[1];
        if (mode == 1) b = 1'b0;
        if (mode == 2 && v == 5'd7) b = ~b;
        return b;
    endfunction

    always_comb begin
        f_ref = fref_fn(vec, ref_mode);
        f_red = f_ref;
        case (red_mode)
            1: f_red = f_ref ^ (vec == 5'd13);
            2: f_red = ~f_ref;
            3: f_red = f_ref ^ ((vec == 5'd5) || (vec == 5'd31));
            default: f_red = f_ref;
        endcase
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Monitor: vec sequence while busy, latency and results on each done rise.
    initial begin
        int unsigned cyc;
        bit bp, dp;
        exp_t e;
        cyc = 0; bp = 0; dp = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                bp = 0; dp = 0;
            end else begin
                if (busy && !bp) cyc = 0;
                if (busy) begin
                    check("vec_seq", vec, cyc / SETTLE);
                    cyc++;
                end
                if (done && !dp) begin
                    check("latency", cyc, LAT);
                    check("vec_wrap", vec, 0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done with empty scoreboard, want none");
                    end else begin
                        e = sb.pop_front();
                        check("err_count", err_count, e.errs);
                        check("first_err", first_err, e.first);
                        check("pass", pass, e.ok);
                    end
                end
                bp = busy;
                dp = done;
            end
        end
    end

    task automatic pulse_start(input int unsigned errs, input int unsigned first, input bit ok);
        exp_t e;
        e.errs = errs; e.first = first; e.ok = ok;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, want done=1", n);
        end
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("retrigger_busy", busy, 1);
    endtask

`ifdef VERIFICADOR_FIRMA_EN
    function automatic logic [15:0] misr_model(int mode);
        logic [15:0] r;
        logic        fb;
        r = 16'h0000;
        for (int v = 0; v < 32; v++) begin
            fb = r[15] ^ fref_fn(5'(v), mode);
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vec", vec, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_first", first_err, 0);
        reset = 1'b1;
        @(negedge clk);

        red_mode = 0; pulse_start(0, 0, 1);  wait_done();
        check("done_hold_pass", pass, 1);
        red_mode = 1; pulse_start(1, 13, 0); wait_done();
        red_mode = 2; pulse_start(32, 0, 0); wait_done();
        red_mode = 3; pulse_start(2, 5, 0);  wait_done();

        // start pulses mid-sweep must be ignored
        red_mode = 0; pulse_start(0, 0, 1);
        repeat (9) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (29) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done();
        @(negedge clk);
        check("single_sweep", sb.size(), 0);

        // start held high re-triggers from DONE
        red_mode = 1;
        begin
            exp_t e;
            e.errs = 1; e.first = 13; e.ok = 0;
            sb.push_back(e);
            sb.push_back(e);
        end
        start = 1'b1;
        @(negedge clk);
        wait_done();
        wait_busy();
        wait_done();
        start = 1'b0;
        @(negedge clk);
        check("held_stop", busy, 0);

        // asynchronous reset mid-sweep discards partial results
        red_mode = 2; pulse_start(32, 0, 0);
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_vec", vec, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", pass, 0);
        check("midrst_err", err_count, 0);
        check("midrst_first", first_err, 0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        red_mode = 1; pulse_start(1, 13, 0); wait_done();

`ifdef VERIFICADOR_FIRMA_EN
        red_mode = 0;
        ref_mode = 1; pulse_start(0, 0, 1); wait_done();
        check("firma_zero", firma, 16'h0000);
        ref_mode = 0; pulse_start(0, 0, 1); wait_done();
        check("firma_run1", firma, misr_model(0));
        pulse_start(0, 0, 1); wait_done();
        check("firma_run2", firma, misr_model(0));
        ref_mode = 2; pulse_start(0, 0, 1); wait_done();
        check("firma_flip7", firma, misr_model(2));
        checks++;
        if (misr_model(2) == misr_model(0)) begin
            errors++;
            $display("FAIL firma_distinct: got equal signatures, want different");
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
